// File: rtl/match_mem_bank.sv
// Keypoint record storage bank: one logical port spread over point, depth and descriptor SRAM
// macros, with a registered macro interface, aligned read pipeline and self-timed zero-fill.
module match_mem_bank #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned POINT_W        = 20,
    parameter int unsigned DEPTH_W        = 16,
    parameter int unsigned DESC_WORDS     = 8,
    parameter int unsigned DESC_W         = 32,
    parameter int unsigned SRAM_LAT       = 1,
    parameter int unsigned CLEAR_ON_RESET = 0,
    localparam int unsigned NUM_MACRO     = DESC_WORDS + 2,
    localparam int unsigned WORD_W        = POINT_W + DEPTH_W + DESC_WORDS * DESC_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_we,
    input  logic [ADDR_W-1:0]           i_req_addr,
    input  logic [WORD_W-1:0]           i_req_wdata,
    input  logic [NUM_MACRO-1:0]        i_req_wmask,
    output logic                        o_rvalid,
    output logic [WORD_W-1:0]           o_rdata,
    input  logic                        i_clear,
    output logic                        o_busy,
    output logic                        o_clear_done,
    output logic                        o_err_oor,
    output logic [NUM_MACRO-1:0]        o_sram_cen,
    output logic [NUM_MACRO-1:0]        o_sram_wen,
    output logic [NUM_MACRO*ADDR_W-1:0] o_sram_a,
    output logic [WORD_W-1:0]           o_sram_d,
    input  logic [WORD_W-1:0]           i_sram_q
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 start_q, start_d;
    logic [NUM_MACRO-1:0] cen_q, cen_d;
    logic [NUM_MACRO-1:0] wen_q, wen_d;
    logic [ADDR_W-1:0]    a_q, a_d;
    logic [WORD_W-1:0]    d_q, d_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [SRAM_LAT:0]    pv_q, po_q;
    logic                 rvalid_q;
    logic [WORD_W-1:0]    rdata_q;
    logic                 accept, oor, rd_acc, rd_oor;

    // A pending auto-clear blocks requests so the first cycle after reset cannot race it.
    assign o_req_ready = (state_q == StIdle) && !i_clear && !start_q;
    assign accept      = i_req_valid && o_req_ready;
    assign oor         = 32'(i_req_addr) >= DEPTH;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        cen_d   = '1;
        wen_d   = '1;
        a_d     = a_q;
        d_d     = d_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rd_acc  = 1'b0;
        rd_oor  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_clear || start_q) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    start_d = 1'b0;
                    err_d   = 1'b0;
                end else if (accept) begin
                    if (oor) begin
                        err_d = 1'b1;
                    end
                    if (!i_req_we) begin
                        rd_acc = 1'b1;
                        rd_oor = oor;
                    end
                    if (!oor) begin
                        a_d = i_req_addr;
                        if (i_req_we) begin
                            cen_d = ~i_req_wmask;
                            wen_d = ~i_req_wmask;
                            d_d   = i_req_wdata;
                        end else begin
                            cen_d = '0;
                        end
                    end
                end
            end
            StClear: begin
                cen_d = '0;
                wen_d = '0;
                a_d   = cnt_q;
                d_d   = '0;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            start_q  <= (CLEAR_ON_RESET != 0);
            cen_q    <= '1;
            wen_q    <= '1;
            a_q      <= '0;
            d_q      <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            pv_q     <= '0;
            po_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            a_q     <= a_d;
            d_q     <= d_d;
            err_q   <= err_d;
            done_q  <= done_d;
            // Stage SRAM_LAT lines up with Q of the read issued at the accept edge.
            pv_q[0] <= rd_acc;
            po_q[0] <= rd_oor;
            for (int i = 1; i <= SRAM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                po_q[i] <= po_q[i-1];
            end
            rvalid_q <= pv_q[SRAM_LAT];
            if (pv_q[SRAM_LAT]) begin
                rdata_q <= po_q[SRAM_LAT] ? '0 : i_sram_q;
            end
        end
    end

    assign o_busy       = (state_q == StClear);
    assign o_clear_done = done_q;
    assign o_err_oor    = err_q;
    assign o_sram_cen   = cen_q;
    assign o_sram_wen   = wen_q;
    assign o_sram_a     = {NUM_MACRO{a_q}};
    assign o_sram_d     = d_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;

endmodule
